// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, types and constants for the multi-port register file
package regfile_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_NREGS = 32;
  localparam int AW = $clog2(DEF_NREGS);
  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DEF_XLEN-1:0] xlen_t;
  localparam reg_addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write, reservation and flush bus of the multi-port register file
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) ();
  localparam int AW = $clog2(NREGS);
  logic [NUM_RD-1:0][AW-1:0] rd_addr_i;
  logic [NUM_RD-1:0][XLEN-1:0] rd_data_o;
  logic [NUM_RD-1:0] rd_busy_o;
  logic [NUM_WR-1:0] wr_en_i;
  logic [NUM_WR-1:0][AW-1:0] wr_addr_i;
  logic [NUM_WR-1:0][XLEN-1:0] wr_data_i;
  logic rsv_en_i;
  logic [AW-1:0] rsv_addr_i;
  logic rsv_ok_o;
  logic flush_i;
  logic [AW:0] busy_cnt_o;
  modport slave (
    input rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i, flush_i,
    output rd_data_o, rd_busy_o, rsv_ok_o, busy_cnt_o
  );
  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i, flush_i,
    input rd_data_o, rd_busy_o, rsv_ok_o, busy_cnt_o
  );
endinterface

// File: rtl/regfile_busy_tracker.sv
// regfile_busy_tracker: busy-bit scoreboard with reservation, writeback clear, flush and busy count
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NUM_WR = 2,
  parameter int ZERO_REG = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic [NUM_WR-1:0] wr_en_i,
  input  logic [NUM_WR-1:0][$clog2(NREGS)-1:0] wr_addr_i,
  input  logic rsv_en_i,
  input  logic [$clog2(NREGS)-1:0] rsv_addr_i,
  input  logic flush_i,
  output logic [NREGS-1:0] busy_o,
  output logic rsv_ok_o,
  output logic [$clog2(NREGS):0] busy_cnt_o
);
  localparam int AW = $clog2(NREGS);
  localparam bit ZR = ZERO_REG != 0;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0] cnt_q;
  logic rsv_zero, rsv_wr, rsv_acc;
  // next busy vector: writeback clears, accepted reservation sets (wins), flush clears all
  always_comb begin
    rsv_wr = 1'b0;
    for (int j = 0; j < NUM_WR; j++) rsv_wr = rsv_wr | (wr_en_i[j] && wr_addr_i[j] == rsv_addr_i);
    rsv_zero = ZR && rsv_addr_i == AW'(ZERO_ADDR);
    rsv_acc = rsv_en_i && (rsv_zero || !busy_q[rsv_addr_i] || rsv_wr);
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) if (wr_en_i[j]) busy_d[wr_addr_i[j]] = 1'b0;
    if (rsv_acc && !rsv_zero) busy_d[rsv_addr_i] = 1'b1;
    busy_d = flush_i ? '0 : busy_d;
    if (ZR) busy_d[0] = 1'b0;
  end
  // busy vector and its registered population count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= (AW + 1)'($countones(busy_d));
    end
  end
  assign rsv_ok_o = !rsv_en_i || rsv_acc;
  assign busy_o = busy_q;
  assign busy_cnt_o = cnt_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with busy scoreboard; REGFILE_BYPASS_EN enables write-to-read forwarding
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int ZERO_REG = 1
) (
  input logic clk_i,
  input logic rst_ni,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam bit ZR = ZERO_REG != 0;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NUM_RD-1:0][XLEN-1:0] rd_data;
  logic [NUM_RD-1:0] rd_busy;
  regfile_busy_tracker #(.NREGS(NREGS), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)) u_busy (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .wr_en_i(bus.wr_en_i),
    .wr_addr_i(bus.wr_addr_i),
    .rsv_en_i(bus.rsv_en_i),
    .rsv_addr_i(bus.rsv_addr_i),
    .flush_i(bus.flush_i),
    .busy_o(busy),
    .rsv_ok_o(bus.rsv_ok_o),
    .busy_cnt_o(bus.busy_cnt_o)
  );
  // writes applied high-to-low port index so the lowest enabled port lands last and wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int j = NUM_WR - 1; j >= 0; j--)
        if (bus.wr_en_i[j] && !(ZR && bus.wr_addr_i[j] == AW'(ZERO_ADDR)))
          regs[bus.wr_addr_i[j]] <= bus.wr_data_i[j];
    end
  end
  // combinational reads with optional same-cycle forwarding; zero register masks everything
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i] = regs[bus.rd_addr_i[i]];
      rd_busy[i] = busy[bus.rd_addr_i[i]];
`ifdef REGFILE_BYPASS_EN
      for (int j = NUM_WR - 1; j >= 0; j--)
        if (bus.wr_en_i[j] && bus.wr_addr_i[j] == bus.rd_addr_i[i]) begin
          rd_data[i] = bus.wr_data_i[j];
          rd_busy[i] = 1'b0;
        end
`else
`endif
      if (ZR && bus.rd_addr_i[i] == AW'(ZERO_ADDR)) begin
        rd_data[i] = '0;
        rd_busy[i] = 1'b0;
      end
    end
  end
  assign bus.rd_data_o = rd_data;
  assign bus.rd_busy_o = rd_busy;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp
module tb_regfile_mp;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) ifc ();
  regfile_mp dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(ifc.slave));
  always #5 clk_i = ~clk_i;

  task automatic idle();
    ifc.wr_en_i = '0;
    ifc.wr_addr_i = '0;
    ifc.wr_data_i = '0;
    ifc.rsv_en_i = 1'b0;
    ifc.rsv_addr_i = '0;
    ifc.flush_i = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
    idle();
  endtask

  task automatic test_reset();
    ifc.rd_addr_i[0] = 5'd5;
    ifc.rd_addr_i[1] = 5'd8;
    #1;
    n_cmp++; if (ifc.busy_cnt_o !== 6'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", ifc.busy_cnt_o); end
    n_cmp++; if (ifc.rd_data_o[0] !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", ifc.rd_data_o[0]); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    ifc.wr_en_i[0] = 1'b1; ifc.wr_addr_i[0] = 5'd5; ifc.wr_data_i[0] = 32'hDEADBEEF;
    ifc.rsv_en_i = 1'b1; ifc.rsv_addr_i = 5'd8;
    cyc();
    #1;
    n_cmp++; if (ifc.rd_data_o[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL pre_reset_data: got %h want deadbeef", ifc.rd_data_o[0]); end
    n_cmp++; if (ifc.rd_busy_o[1] !== 1'b1) begin n_bad++; $display("FAIL pre_reset_busy: got %b want 1", ifc.rd_busy_o[1]); end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (ifc.rd_data_o[0] !== 32'h0) begin n_bad++; $display("FAIL midrun_reset_data: got %h want 0", ifc.rd_data_o[0]); end
    n_cmp++; if (ifc.rd_busy_o[1] !== 1'b0) begin n_bad++; $display("FAIL midrun_reset_busy: got %b want 0", ifc.rd_busy_o[1]); end
    n_cmp++; if (ifc.busy_cnt_o !== 6'd0) begin n_bad++; $display("FAIL midrun_reset_cnt: got %0d want 0", ifc.busy_cnt_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_wr_priority();
    cyc();
    ifc.wr_en_i = 2'b11;
    ifc.wr_addr_i[0] = 5'd7; ifc.wr_data_i[0] = 32'h11;
    ifc.wr_addr_i[1] = 5'd7; ifc.wr_data_i[1] = 32'h22;
    cyc();
    ifc.rd_addr_i[0] = 5'd7;
    #1;
    n_cmp++; if (ifc.rd_data_o[0] !== 32'h11) begin n_bad++; $display("FAIL wr_priority: got %h want 11", ifc.rd_data_o[0]); end
    ifc.wr_en_i[1] = 1'b1; ifc.wr_addr_i[1] = 5'd0; ifc.wr_data_i[1] = 32'hFF;
    cyc();
    ifc.rd_addr_i[1] = 5'd0;
    #1;
    n_cmp++; if (ifc.rd_data_o[1] !== 32'h0) begin n_bad++; $display("FAIL x0_write: got %h want 0", ifc.rd_data_o[1]); end
  endtask

  task automatic test_reserve();
    ifc.rsv_en_i = 1'b1; ifc.rsv_addr_i = 5'd3;
    #1;
    n_cmp++; if (ifc.rsv_ok_o !== 1'b1) begin n_bad++; $display("FAIL rsv_first_ok: got %b want 1", ifc.rsv_ok_o); end
    cyc();
    ifc.rd_addr_i[0] = 5'd3;
    #1;
    n_cmp++; if (ifc.rd_busy_o[0] !== 1'b1) begin n_bad++; $display("FAIL rsv_busy: got %b want 1", ifc.rd_busy_o[0]); end
    n_cmp++; if (ifc.busy_cnt_o !== 6'd1) begin n_bad++; $display("FAIL rsv_cnt: got %0d want 1", ifc.busy_cnt_o); end
    ifc.rsv_en_i = 1'b1; ifc.rsv_addr_i = 5'd3;
    #1;
    n_cmp++; if (ifc.rsv_ok_o !== 1'b0) begin n_bad++; $display("FAIL rsv_second_ok: got %b want 0", ifc.rsv_ok_o); end
    cyc();
    n_cmp++; if (ifc.busy_cnt_o !== 6'd1) begin n_bad++; $display("FAIL rsv_reject_cnt: got %0d want 1", ifc.busy_cnt_o); end
    ifc.wr_en_i[1] = 1'b1; ifc.wr_addr_i[1] = 5'd3; ifc.wr_data_i[1] = 32'h55;
    cyc();
    #1;
    n_cmp++; if (ifc.rd_busy_o[0] !== 1'b0) begin n_bad++; $display("FAIL wb_busy: got %b want 0", ifc.rd_busy_o[0]); end
    n_cmp++; if (ifc.rd_data_o[0] !== 32'h55) begin n_bad++; $display("FAIL wb_data: got %h want 55", ifc.rd_data_o[0]); end
    n_cmp++; if (ifc.busy_cnt_o !== 6'd0) begin n_bad++; $display("FAIL wb_cnt: got %0d want 0", ifc.busy_cnt_o); end
    ifc.rsv_en_i = 1'b1; ifc.rsv_addr_i = 5'd0;
    #1;
    n_cmp++; if (ifc.rsv_ok_o !== 1'b1) begin n_bad++; $display("FAIL rsv_x0_ok: got %b want 1", ifc.rsv_ok_o); end
    cyc();
    n_cmp++; if (ifc.busy_cnt_o !== 6'd0) begin n_bad++; $display("FAIL rsv_x0_cnt: got %0d want 0", ifc.busy_cnt_o); end
  endtask

  task automatic test_clear_set();
    ifc.rsv_en_i = 1'b1; ifc.rsv_addr_i = 5'd9;
    cyc();
    ifc.rd_addr_i[0] = 5'd9;
    ifc.wr_en_i[0] = 1'b1; ifc.wr_addr_i[0] = 5'd9; ifc.wr_data_i[0] = 32'hA;
    ifc.rsv_en_i = 1'b1; ifc.rsv_addr_i = 5'd9;
    #1;
    n_cmp++; if (ifc.rsv_ok_o !== 1'b1) begin n_bad++; $display("FAIL clrset_ok: got %b want 1", ifc.rsv_ok_o); end
    cyc();
    #1;
    n_cmp++; if (ifc.rd_busy_o[0] !== 1'b1) begin n_bad++; $display("FAIL clrset_busy: got %b want 1", ifc.rd_busy_o[0]); end
    n_cmp++; if (ifc.rd_data_o[0] !== 32'hA) begin n_bad++; $display("FAIL clrset_data: got %h want a", ifc.rd_data_o[0]); end
    n_cmp++; if (ifc.busy_cnt_o !== 6'd1) begin n_bad++; $display("FAIL clrset_cnt: got %0d want 1", ifc.busy_cnt_o); end
    ifc.wr_en_i[0] = 1'b1; ifc.wr_addr_i[0] = 5'd9; ifc.wr_data_i[0] = 32'hA;
    cyc();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      ifc.rsv_en_i = 1'b1;
      ifc.rsv_addr_i = (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : 5'd4;
      cyc();
    end
    #1;
    n_cmp++; if (ifc.busy_cnt_o !== 6'd3) begin n_bad++; $display("FAIL flush_pre_cnt: got %0d want 3", ifc.busy_cnt_o); end
    ifc.flush_i = 1'b1;
    ifc.rsv_en_i = 1'b1; ifc.rsv_addr_i = 5'd6;
    ifc.wr_en_i[0] = 1'b1; ifc.wr_addr_i[0] = 5'd10; ifc.wr_data_i[0] = 32'h77;
    #1;
    n_cmp++; if (ifc.rsv_ok_o !== 1'b1) begin n_bad++; $display("FAIL flush_rsv_ok: got %b want 1", ifc.rsv_ok_o); end
    cyc();
    ifc.rd_addr_i[0] = 5'd6;
    ifc.rd_addr_i[1] = 5'd1;
    #1;
    n_cmp++; if (ifc.busy_cnt_o !== 6'd0) begin n_bad++; $display("FAIL flush_cnt: got %0d want 0", ifc.busy_cnt_o); end
    n_cmp++; if (ifc.rd_busy_o !== 2'b00) begin n_bad++; $display("FAIL flush_busy: got %b want 00", ifc.rd_busy_o); end
    ifc.rd_addr_i[0] = 5'd10;
    #1;
    n_cmp++; if (ifc.rd_data_o[0] !== 32'h77) begin n_bad++; $display("FAIL flush_write: got %h want 77", ifc.rd_data_o[0]); end
  endtask

  task automatic test_bypass();
    ifc.rsv_en_i = 1'b1; ifc.rsv_addr_i = 5'd13;
    cyc();
    ifc.rd_addr_i[0] = 5'd12;
    ifc.rd_addr_i[1] = 5'd13;
    ifc.wr_en_i = 2'b11;
    ifc.wr_addr_i[0] = 5'd13; ifc.wr_data_i[0] = 32'h99;
    ifc.wr_addr_i[1] = 5'd12; ifc.wr_data_i[1] = 32'h1234;
    #1;
`ifdef REGFILE_BYPASS_EN
    n_cmp++; if (ifc.rd_data_o[0] !== 32'h1234) begin n_bad++; $display("FAIL bypass_data: got %h want 1234", ifc.rd_data_o[0]); end
    n_cmp++; if (ifc.rd_busy_o[1] !== 1'b0) begin n_bad++; $display("FAIL bypass_busy: got %b want 0", ifc.rd_busy_o[1]); end
`else
    n_cmp++; if (ifc.rd_data_o[0] !== 32'h0) begin n_bad++; $display("FAIL nobypass_data: got %h want 0", ifc.rd_data_o[0]); end
    n_cmp++; if (ifc.rd_busy_o[1] !== 1'b1) begin n_bad++; $display("FAIL nobypass_busy: got %b want 1", ifc.rd_busy_o[1]); end
`endif
    cyc();
    #1;
    n_cmp++; if (ifc.rd_data_o[0] !== 32'h1234) begin n_bad++; $display("FAIL bypass_next_data: got %h want 1234", ifc.rd_data_o[0]); end
    n_cmp++; if (ifc.rd_data_o[1] !== 32'h99) begin n_bad++; $display("FAIL bypass_next_data1: got %h want 99", ifc.rd_data_o[1]); end
    ifc.rd_addr_i[0] = 5'd0;
    ifc.wr_en_i[0] = 1'b1; ifc.wr_addr_i[0] = 5'd0; ifc.wr_data_i[0] = 32'hBAD;
    #1;
    n_cmp++; if (ifc.rd_data_o[0] !== 32'h0) begin n_bad++; $display("FAIL x0_no_bypass: got %h want 0", ifc.rd_data_o[0]); end
    cyc();
  endtask

  task automatic test_back_to_back();
    for (int r = 1; r < 32; r++) begin
      ifc.rsv_en_i = 1'b1;
      ifc.rsv_addr_i = 5'(r);
      cyc();
    end
    #1;
    n_cmp++; if (ifc.busy_cnt_o !== 6'd31) begin n_bad++; $display("FAIL all_busy_cnt: got %0d want 31", ifc.busy_cnt_o); end
    ifc.rsv_en_i = 1'b1; ifc.rsv_addr_i = 5'd31;
    #1;
    n_cmp++; if (ifc.rsv_ok_o !== 1'b0) begin n_bad++; $display("FAIL all_busy_rsv: got %b want 0", ifc.rsv_ok_o); end
    ifc.flush_i = 1'b1;
    cyc();
    #1;
    n_cmp++; if (ifc.busy_cnt_o !== 6'd0) begin n_bad++; $display("FAIL all_flush_cnt: got %0d want 0", ifc.busy_cnt_o); end
  endtask

  initial begin
    idle();
    ifc.rd_addr_i = '0;
    test_reset();
    test_wr_priority();
    test_reserve();
    test_clear_set();
    test_flush();
    test_bypass();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
